// File: rtl/grid_vga_pkg.sv
// grid_vga_pkg: VGA 640x480@60 timing constants, colour type and default colours
package grid_vga_pkg;
  typedef logic [11:0] rgb444_t;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam rgb444_t CELL_RGB   = 12'hF80;
  localparam rgb444_t BG_RGB     = 12'h000;
  localparam rgb444_t BORDER_RGB = 12'hFFF;
  localparam rgb444_t BLANK_RGB  = 12'h000;
endpackage

// File: rtl/grid_vga_if.sv
// grid_vga_if: playfield input and VGA output bundle of the renderer
interface grid_vga_if;
  import grid_vga_pkg::*;
  logic [255:0] grid_out;
  logic hsync;
  logic vsync;
  rgb444_t rgb;
  logic frame_tick;
  modport master (input grid_out, output hsync, vsync, rgb, frame_tick);
  modport slave (output grid_out, input hsync, vsync, rgb, frame_tick);
endinterface

// File: rtl/grid_vga_renderer_timing.sv
// vga_timing: pixel-enable divider, raster counters, raw syncs and visible flag
module vga_timing import grid_vga_pkg::*; #(
  parameter int HV  = H_VIS,
  parameter int HFP = H_FP,
  parameter int HS  = H_SYNC,
  parameter int HB  = H_BP,
  parameter int VV  = V_VIS,
  parameter int VFP = V_FP,
  parameter int VS  = V_SYNC,
  parameter int VB  = V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en_o,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       visible_o
);
  logic [1:0] div_q;
  logic [9:0] h_q, v_q;
  logic h_last, v_last;
  assign pix_en_o = div_q == 2'd3;
  assign h_last = h_q == 10'(HV + HFP + HS + HB - 1);
  assign v_last = v_q == 10'(VV + VFP + VS + VB - 1);
  assign hcount_o = h_q;
  assign vcount_o = v_q;
  assign hsync_o = !(h_q >= 10'(HV + HFP) && h_q < 10'(HV + HFP + HS));
  assign vsync_o = !(v_q >= 10'(VV + VFP) && v_q < 10'(VV + VFP + VS));
  assign visible_o = h_q < 10'(HV) && v_q < 10'(VV);
  always_ff @(posedge clk)
    if (reset) begin
      div_q <= '0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      div_q <= div_q + 2'd1;
      if (pix_en_o) begin
        h_q <= h_last ? '0 : h_q + 10'd1;
        if (h_last) v_q <= v_last ? '0 : v_q + 10'd1;
      end
    end
endmodule

// File: rtl/grid_vga_renderer.sv
// grid_vga_renderer: draws the 16x16 playfield snapshot, bordered, onto VGA
module grid_vga_renderer import grid_vga_pkg::*; #(
  parameter int CELL_PX = 16,
  parameter int X_ORIGIN = 192,
  parameter int Y_ORIGIN = 112,
  parameter rgb444_t CELL_COLOR = CELL_RGB,
  parameter rgb444_t BG_COLOR = BG_RGB,
  parameter rgb444_t BORDER_COLOR = BORDER_RGB,
  parameter int HV  = H_VIS,
  parameter int HFP = H_FP,
  parameter int HS  = H_SYNC,
  parameter int HB  = H_BP,
  parameter int VV  = V_VIS,
  parameter int VFP = V_FP,
  parameter int VS  = V_SYNC,
  parameter int VB  = V_BP
) (
  input logic clk,
  input logic reset,
  grid_vga_if.master bus_io
);
  localparam int SH = $clog2(CELL_PX);
  localparam logic signed [10:0] LO = -11'sd1;
  localparam logic signed [10:0] HI = 11'(16 * CELL_PX);
  logic pix_en, hs, vs, vis, snap_d, border_d, cell_d;
  logic [9:0] h, v;
  logic signed [10:0] xs, ys;
  logic [3:0] col, row;
  logic [255:0] shadow_q;
  logic ft_q, s1_vis_q, s1_bord_q, s1_cell_q, s1_hs_q, s1_vs_q, hs_q, vs_q;
  rgb444_t rgb_q, rgb_d;
  vga_timing #(.HV(HV), .HFP(HFP), .HS(HS), .HB(HB), .VV(VV), .VFP(VFP), .VS(VS), .VB(VB)) u_timing (
    .clk(clk), .reset(reset), .pix_en_o(pix_en), .hcount_o(h), .vcount_o(v),
    .hsync_o(hs), .vsync_o(vs), .visible_o(vis)
  );
  // signed offsets keep pixels left of / above the board from wrapping into it
  assign xs = 11'({1'b0, h}) - 11'(X_ORIGIN);
  assign ys = 11'({1'b0, v}) - 11'(Y_ORIGIN);
  assign col = xs[SH+3:SH];
  assign row = ys[SH+3:SH];
  always_comb begin
    snap_d = pix_en && h == '0 && v == 10'(VV);
    border_d = xs >= LO && xs <= HI && ys >= LO && ys <= HI &&
               (xs == LO || xs == HI || ys == LO || ys == HI);
    cell_d = !xs[10] && !ys[10] && xs < HI && ys < HI && shadow_q[{col, row}];
    rgb_d = !s1_vis_q ? BLANK_RGB : s1_bord_q ? BORDER_COLOR : s1_cell_q ? CELL_COLOR : BG_COLOR;
  end
  always_ff @(posedge clk)
    if (reset) begin
      shadow_q <= '0;
      ft_q <= 1'b0;
      s1_vis_q <= 1'b0;
      s1_bord_q <= 1'b0;
      s1_cell_q <= 1'b0;
      s1_hs_q <= 1'b1;
      s1_vs_q <= 1'b1;
      rgb_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      ft_q <= snap_d;
      if (snap_d) shadow_q <= bus_io.grid_out;
      if (pix_en) begin
        s1_vis_q <= vis;
        s1_bord_q <= border_d;
        s1_cell_q <= cell_d;
        s1_hs_q <= hs;
        s1_vs_q <= vs;
        rgb_q <= rgb_d;
        hs_q <= s1_hs_q;
        vs_q <= s1_vs_q;
      end
    end
  assign bus_io.hsync = hs_q;
  assign bus_io.vsync = vs_q;
  assign bus_io.rgb = rgb_q;
  assign bus_io.frame_tick = ft_q;
endmodule

// File: tb/tb_grid_vga_renderer.sv
// tb_grid_vga_renderer: directed checks on a full-size and a scaled-down renderer
module tb_grid_vga_renderer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int t = 0;
  int ft_cnt = 0;
  logic [255:0] g;
  grid_vga_if bus_d ();
  grid_vga_if bus_s ();
  grid_vga_renderer u_def (.clk(clk), .reset(reset), .bus_io(bus_d));
  // small raster 64x48 (visible 48x40), 2-px cells: board x8..39, y4..35
  grid_vga_renderer #(
    .CELL_PX(2), .X_ORIGIN(8), .Y_ORIGIN(4),
    .HV(48), .HFP(4), .HS(8), .HB(4), .VV(40), .VFP(2), .VS(2), .VB(4)
  ) u_sml (.clk(clk), .reset(reset), .bus_io(bus_s));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus_s.frame_tick) ft_cnt <= ft_cnt + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic at(input int e);
    repeat (e - t) @(posedge clk);
    t = e;
    #1;
  endtask
  function automatic int pe(input int x, input int y, input int f);
    return 4 * (f * 3072 + y * 64 + x + 2);
  endfunction
  task automatic chk_rst(input string tag);
    chk({tag, "_d_hs"}, 32'(bus_d.hsync), 32'd1);
    chk({tag, "_d_vs"}, 32'(bus_d.vsync), 32'd1);
    chk({tag, "_d_rgb"}, 32'(bus_d.rgb), 32'h000);
    chk({tag, "_d_ft"}, 32'(bus_d.frame_tick), 32'd0);
    chk({tag, "_s_hs"}, 32'(bus_s.hsync), 32'd1);
    chk({tag, "_s_vs"}, 32'(bus_s.vsync), 32'd1);
    chk({tag, "_s_rgb"}, 32'(bus_s.rgb), 32'h000);
    chk({tag, "_s_ft"}, 32'(bus_s.frame_tick), 32'd0);
  endtask
  initial begin
    bus_d.grid_out = '0;
    bus_s.grid_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    reset = 1'b0;
    t = 0;
    g = '0;
    g[0] = 1'b1;
    g[17] = 1'b1;
    bus_d.grid_out = g;
    bus_s.grid_out = g;
    at(215);  chk("s_hs_pre", 32'(bus_s.hsync), 32'd1);
    at(216);  chk("s_hs_fall", 32'(bus_s.hsync), 32'd0);
    at(pe(6, 3, 0));   chk("f0_out_6_3", 32'(bus_s.rgb), 32'h000);
    at(pe(7, 3, 0));   chk("f0_corner_7_3", 32'(bus_s.rgb), 32'hFFF);
    at(pe(8, 4, 0));   chk("f0_empty_8_4", 32'(bus_s.rgb), 32'h000);
    at(2631); chk("d_hs_pre", 32'(bus_d.hsync), 32'd1);
    at(2632); chk("d_hs_fall", 32'(bus_d.hsync), 32'd0);
    at(pe(50, 10, 0)); chk("f0_hblank", 32'(bus_s.rgb), 32'h000);
    at(3015); chk("d_hs_low_end", 32'(bus_d.hsync), 32'd0);
    at(3016); chk("d_hs_rise", 32'(bus_d.hsync), 32'd1);
    at(pe(40, 20, 0)); chk("f0_right_40_20", 32'(bus_s.rgb), 32'hFFF);
    at(pe(41, 20, 0)); chk("f0_out_41_20", 32'(bus_s.rgb), 32'h000);
    at(5831); chk("d_hs_pre2", 32'(bus_d.hsync), 32'd1);
    at(5832); chk("d_hs_fall2", 32'(bus_d.hsync), 32'd0);
    at(pe(20, 36, 0)); chk("f0_bottom_20_36", 32'(bus_s.rgb), 32'hFFF);
    at(10243); chk("ft_pre", 32'(bus_s.frame_tick), 32'd0);
    at(10244); chk("ft_pulse", 32'(bus_s.frame_tick), 32'd1);
    at(10245); chk("ft_post", 32'(bus_s.frame_tick), 32'd0);
    at(10759); chk("s_vs_pre", 32'(bus_s.vsync), 32'd1);
    at(10760); chk("s_vs_fall", 32'(bus_s.vsync), 32'd0);
    at(11271); chk("s_vs_low_end", 32'(bus_s.vsync), 32'd0);
    at(11272); chk("s_vs_rise", 32'(bus_s.vsync), 32'd1);
    at(pe(8, 4, 1));   chk("f1_bit0_8_4", 32'(bus_s.rgb), 32'hF80);
    at(pe(10, 4, 1));  chk("f1_bit16_10_4", 32'(bus_s.rgb), 32'h000);
    at(pe(9, 5, 1));   chk("f1_bit0_9_5", 32'(bus_s.rgb), 32'hF80);
    at(pe(10, 6, 1));  chk("f1_bit17_10_6", 32'(bus_s.rgb), 32'hF80);
    at(pe(11, 7, 1));  chk("f1_bit17_11_7", 32'(bus_s.rgb), 32'hF80);
    at(pe(12, 7, 1));  chk("f1_bit33_12_7", 32'(bus_s.rgb), 32'h000);
    at(pe(0, 20, 1) - 8);
    bus_d.grid_out = '1;
    bus_s.grid_out = '1;
    at(pe(30, 30, 1)); chk("f1_isolated_30_30", 32'(bus_s.rgb), 32'h000);
    at(22540); chk("ft_count_2", 32'(ft_cnt), 32'd2);
    at(pe(0, 45, 1));  chk("f1_vblank", 32'(bus_s.rgb), 32'h000);
    at(pe(8, 4, 2));   chk("f2_full_8_4", 32'(bus_s.rgb), 32'hF80);
    at(pe(30, 30, 2)); chk("f2_full_30_30", 32'(bus_s.rgb), 32'hF80);
    at(pe(39, 35, 2)); chk("f2_full_39_35", 32'(bus_s.rgb), 32'hF80);
    at(pe(40, 35, 2)); chk("f2_border_40_35", 32'(bus_s.rgb), 32'hFFF);
    at(34304);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_rst("midreset");
    reset = 1'b0;
    t = 0;
    at(215);  chk("r_s_hs_pre", 32'(bus_s.hsync), 32'd1);
    at(216);  chk("r_s_hs_fall", 32'(bus_s.hsync), 32'd0);
    at(pe(8, 4, 0)); chk("r_empty_8_4", 32'(bus_s.rgb), 32'h000);
    at(2632); chk("r_d_hs_fall", 32'(bus_d.hsync), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/grid_vga_renderer.md
# grid_vga_renderer

Display-side reader of the Tetris playfield. It takes the 256-bit flattened grid from the grid engine and generates standard 640x480@60 VGA timing. It draws the 16x16 board as solid cells inside a one-pixel border, centred on screen. The board is snapshotted once per frame during vertical blanking, so a frame never shows a half-updated board.

## Interface
- CELL_PX, 16: cell edge in pixels (board = 16*CELL_PX square).
- X_ORIGIN, 192: screen x of column 0 left edge.
- Y_ORIGIN, 112: screen y of row 0 top edge.
- CELL_COLOR, 12'hF80: RGB444 of an occupied cell.
- BG_COLOR, 12'h000: RGB444 of an empty cell and of off-board visible pixels.
- BORDER_COLOR, 12'hFFF: RGB444 of the one-pixel board outline.
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high.
- grid_out  in  256  playfield from grid engine; cell(row r, col c) = grid_out[c*16 + r]; row 0 is top.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}.
- frame_tick  out  1  one-clk pulse when the grid snapshot is taken.

## Operation
- Pixel enable: 2-bit divider on clk; pix_en high when divider==3, giving 25 MHz. All state below advances only on pix_en, except that the divider always counts.
- Counters: hcount 0..799 wraps to 0 and increments vcount; vcount 0..524 wraps to 0.
- H timing: visible 0-639, front porch 640-655, sync 656-751 (low), back porch 752-799.
- V timing: visible 0-479, front porch 480-489, sync 490-491 (low), back porch 492-524.
- Snapshot: on the pix_en where (hcount,vcount)=(0,480), copy grid_out into a 256-bit shadow register and pulse frame_tick for that clk. All rendering uses the shadow only.
- Pixel classification, per (x=hcount, y=vcount), in visible region only:
  - Border: x in [X_ORIGIN-1, X_ORIGIN+16*CELL_PX] and y in [Y_ORIGIN-1, Y_ORIGIN+16*CELL_PX], lying on that rectangle's perimeter -> BORDER_COLOR.
  - Inside: col=(x-X_ORIGIN)/CELL_PX, row=(y-Y_ORIGIN)/CELL_PX. Shadow bit col*16+row -> CELL_COLOR if 1, else BG_COLOR.
  - Otherwise -> BG_COLOR.
- Blanking: rgb forced to 12'h000 whenever the source pixel is outside 0-639 x 0-479.
- Arithmetic: counters are 10 bits unsigned. Offsets are computed in 11-bit signed, so x<X_ORIGIN never aliases into the board. CELL_PX must be a power of two, so divide is a shift.

## Timing
- Reset: divider=0, hcount=0, vcount=0, shadow=0, hsync=1, vsync=1, rgb=0, frame_tick=0. Reset held for at least one clk restarts the frame from (0,0), even mid-line.
- Pipeline: 2 pix_en stages. Stage 1 registers the classification and the cell bit. Stage 2 registers rgb. hsync and vsync are delayed by the same 2 stages, so all three outputs refer to the same (hcount,vcount).
- Outputs change only on the clk edge where pix_en is high; they hold for 4 clks.
- grid_out changes at any time after a snapshot affect only the next frame. A grid_out change on the snapshot cycle itself is sampled as presented on that edge.
- The first frame after reset shows an all-empty board until vcount first reaches 480.

## Structure
- Package grid_vga_pkg: H/V visible, porch and sync constants; H_TOTAL=800, V_TOTAL=525; rgb444_t typedef; colour constants.
- Sub-module vga_timing: divider, hcount/vcount, raw hsync/vsync, visible flag, pix_en. The top level holds the shadow, classification pipeline and frame_tick.

## Test plan
- Reset: assert 3 clks -> hsync=1, vsync=1, rgb=0, frame_tick=0. After release, first hsync falling edge at clk 4*(656+2).
- Line and frame timing: hsync period 3200 clks with 384 low. vsync period 1,680,000 clks with 6400 low. frame_tick once per frame.
- Cell mapping: grid_out bit 0 only -> pixels x192-207, y112-127 = 12'hF80. Bit 17 -> x208-223, y128-143 = 12'hF80. All other board pixels 12'h000.
- Border: empty grid -> (191,111), (448,300) and (300,368) = 12'hFFF; (190,111) = 12'h000.
- Snapshot isolation: set all 256 bits at vcount=200 -> no cell change in the current frame; every board pixel = 12'hF80 from the next frame on.
- Blanking and mid-frame reset: rgb=0 throughout hcount 640-799 and vcount 480-524. Reset pulsed at vcount=300 -> counters restart at 0 and outputs return to their reset values.
